// File: rtl/pci_rr_arbiter.sv
// Round-robin central arbiter for a shared PCI-style bus with idle-gated handover and grant timeout.
// Optional bus parking is enabled by defining PCI_ARB_PARK_EN.
//
// state      | meaning
// S_IDLE     | no transaction owned; grant the round-robin winner once the bus is idle (or park)
// S_GRANT    | grant driven, waiting for FRAME#; timer counts toward revocation
// S_BUSY     | owner is running a transaction; drop grant on competing request or owner release
// S_WAIT_IDLE| grant removed, waiting for FRAME# and IRDY# to return high
// S_TURN     | one mandatory all-high turnaround cycle
module pci_rr_arbiter #(
    parameter int N_MASTERS   = 4,
    parameter int OWNER_W     = 2,
    parameter int GNT_TIMEOUT = 16,
    parameter int TMR_W       = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_MASTERS-1:0] req_n,
    input  logic                 frame_n,
    input  logic                 irdy_n,
    output logic [N_MASTERS-1:0] gnt_n,
    output logic [OWNER_W-1:0]   owner,
    output logic                 bus_busy,
    output logic                 timeout_pulse
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_BUSY,
        S_WAIT_IDLE,
        S_TURN
    } state_t;

    localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(GNT_TIMEOUT - 1);
    localparam logic [OWNER_W-1:0]   RR_INIT  = OWNER_W'(N_MASTERS - 1);
    localparam logic [N_MASTERS-1:0] GNT_NONE = '1;

    state_t               state_q, state_d;
    logic [N_MASTERS-1:0] gnt_n_q, gnt_n_d;
    logic [OWNER_W-1:0]   owner_q, owner_d;
    logic [OWNER_W-1:0]   rr_q, rr_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic                 tmo_q, tmo_d;
    logic                 busy_q;

    logic                 any_req;
    logic [OWNER_W-1:0]   winner;
    int                   pick_idx;
    logic                 bus_idle;
    logic                 owner_rel;
    logic                 other_req;

    function automatic logic [N_MASTERS-1:0] sel_low(input logic [OWNER_W-1:0] idx);
        return ~(N_MASTERS'(1) << idx);
    endfunction

    assign bus_idle  = frame_n & irdy_n;
    assign owner_rel = req_n[owner_q];
    assign other_req = ((~req_n) & sel_low(owner_q)) != '0;

    // First low request scanning upward from rr_q+1 with wrap-around.
    always_comb begin
        any_req  = 1'b0;
        winner   = '0;
        pick_idx = 0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            pick_idx = (int'(rr_q) + i) % N_MASTERS;
            if (!any_req && !req_n[pick_idx]) begin
                any_req = 1'b1;
                winner  = OWNER_W'(pick_idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_n_d = gnt_n_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        timer_d = timer_q;
        tmo_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
`ifdef PCI_ARB_PARK_EN
                if (gnt_n_q != GNT_NONE) begin
                    // Parked: the parked master may start directly; a rival costs one all-high cycle.
                    if (!frame_n) begin
                        state_d = S_BUSY;
                        timer_d = '0;
                    end else if (any_req && winner != owner_q) begin
                        gnt_n_d = GNT_NONE;
                    end else if (any_req && bus_idle) begin
                        state_d = S_GRANT;
                        rr_d    = winner;
                        timer_d = '0;
                    end
                end else if (any_req && bus_idle) begin
                    gnt_n_d = sel_low(winner);
                    owner_d = winner;
                    rr_d    = winner;
                    timer_d = '0;
                    state_d = S_GRANT;
                end else if (!any_req) begin
                    gnt_n_d = sel_low(owner_q);
                end
`else
                gnt_n_d = GNT_NONE;
                if (any_req && bus_idle) begin
                    gnt_n_d = sel_low(winner);
                    owner_d = winner;
                    rr_d    = winner;
                    timer_d = '0;
                    state_d = S_GRANT;
                end
`endif
            end
            S_GRANT: begin
                if (!frame_n) begin
                    state_d = S_BUSY;
                    timer_d = '0;
                end else if (owner_rel) begin
                    gnt_n_d = GNT_NONE;
                    state_d = S_TURN;
                end else if (timer_q == TMR_LAST) begin
                    gnt_n_d = GNT_NONE;
                    tmo_d   = 1'b1;
                    state_d = S_TURN;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_BUSY: begin
                if (owner_rel || other_req) begin
                    gnt_n_d = GNT_NONE;
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                gnt_n_d = GNT_NONE;
                if (bus_idle) begin
                    state_d = S_TURN;
                end
            end
            S_TURN: begin
                gnt_n_d = GNT_NONE;
                state_d = S_IDLE;
            end
            default: begin
                gnt_n_d = GNT_NONE;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            gnt_n_q <= GNT_NONE;
            owner_q <= '0;
            rr_q    <= RR_INIT;
            timer_q <= '0;
            tmo_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_n_q <= gnt_n_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            timer_q <= timer_d;
            tmo_q   <= tmo_d;
            busy_q  <= ~bus_idle;
        end
    end

    assign gnt_n         = gnt_n_q;
    assign owner         = owner_q;
    assign bus_busy      = busy_q;
    assign timeout_pulse = tmo_q;

endmodule

// File: tb/tb_pci_rr_arbiter.sv
// Directed self-checking bench for pci_rr_arbiter (default parameters, N_MASTERS=4, GNT_TIMEOUT=16).
module tb_pci_rr_arbiter;

    logic       clk;
    logic       reset_n;
    logic [3:0] req_n;
    logic       frame_n;
    logic       irdy_n;
    logic [3:0] gnt_n;
    logic [1:0] owner;
    logic       bus_busy;
    logic       timeout_pulse;

    int checks = 0;
    int errors = 0;

    pci_rr_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_n        (req_n),
        .frame_n      (frame_n),
        .irdy_n       (irdy_n),
        .gnt_n        (gnt_n),
        .owner        (owner),
        .bus_busy     (bus_busy),
        .timeout_pulse(timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts all-high cycles until some grant appears (bounded).
    task automatic wait_grant(output int gap);
        gap = 0;
        for (int n = 0; n < 30 && gnt_n === 4'hF; n++) begin
            gap++;
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         gap;
        logic [3:0] exp_gnt;

        reset_n = 1'b1;
        req_n   = 4'hF;
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        #1;
        reset_n = 1'b0;
        req_n   = 4'b0000;
        #2;
        chk("reset_gnt", gnt_n, 4'hF);
        chk("reset_owner", owner, 0);
        chk("reset_tmo", timeout_pulse, 0);
        chk("reset_busy", bus_busy, 0);
        step();
        step();
        chk("reset_held_gnt", gnt_n, 4'hF);
        reset_n = 1'b1;
        step();
        chk("first_grant", gnt_n, 4'b1110);
        chk("first_owner", owner, 0);

        // Round-robin with all masters requesting: 0,1,2,3 then 0 again
        for (int k = 0; k < 4; k++) begin
            wait_grant(gap);
            if (k > 0) chk("rr_gap", (gap >= 1) ? 1 : 0, 1);
            exp_gnt = ~(4'b0001 << k);
            chk("rr_gnt", gnt_n, exp_gnt);
            chk("rr_owner", owner, k);
            frame_n = 1'b0;
            step();
            chk("rr_bus_busy", bus_busy, 1);
            step();
            frame_n = 1'b1;
        end
        wait_grant(gap);
        chk("rr_wrap_gap", (gap >= 1) ? 1 : 0, 1);
        chk("rr_wrap_gnt", gnt_n, 4'b1110);
        chk("rr_wrap_owner", owner, 0);
        req_n = 4'hF;
        step();
        chk("owner_release", gnt_n, 4'hF);
        step();

        // Timeout on master 3, then master 1 is next
        req_n = 4'b0111;
        step();
        chk("tmo_grant", gnt_n, 4'b0111);
        chk("tmo_owner", owner, 3);
        req_n = 4'b0101;
        for (int i = 1; i < 16; i++) begin
            step();
            chk("tmo_hold_gnt", gnt_n, 4'b0111);
            chk("tmo_hold_pulse", timeout_pulse, 0);
        end
        step();
        chk("tmo_revoke_gnt", gnt_n, 4'hF);
        chk("tmo_pulse", timeout_pulse, 1);
        step();
        chk("tmo_pulse_width", timeout_pulse, 0);
        chk("tmo_turn_gnt", gnt_n, 4'hF);
        step();
        chk("tmo_next_gnt", gnt_n, 4'b1101);
        chk("tmo_next_owner", owner, 1);

        // Pre-emption of master 1 in BUSY by master 2
        req_n   = 4'b1101;
        frame_n = 1'b0;
        step();
        chk("pre_busy_gnt", gnt_n, 4'b1101);
        chk("pre_busy_flag", bus_busy, 1);
        step();
        chk("pre_keep_gnt", gnt_n, 4'b1101);
        req_n = 4'b1001;
        step();
        chk("pre_release", gnt_n, 4'hF);
        req_n = 4'b1011;
        step();
        chk("pre_wait1", gnt_n, 4'hF);
        frame_n = 1'b1;
        irdy_n  = 1'b0;
        step();
        chk("pre_wait_irdy", gnt_n, 4'hF);
        chk("pre_irdy_busy", bus_busy, 1);
        irdy_n = 1'b1;
        step();
        chk("pre_turn", gnt_n, 4'hF);
        step();
        chk("pre_idle", gnt_n, 4'hF);
        step();
        chk("pre_grant2", gnt_n, 4'b1011);
        chk("pre_owner2", owner, 2);

        // Asynchronous reset in BUSY
        frame_n = 1'b0;
        step();
        chk("ares_busy_gnt", gnt_n, 4'b1011);
        #3;
        reset_n = 1'b0;
        #1;
        chk("ares_gnt", gnt_n, 4'hF);
        chk("ares_owner", owner, 0);
        chk("ares_busy", bus_busy, 0);
        chk("ares_tmo", timeout_pulse, 0);
        frame_n = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();
        chk("ares_regrant", gnt_n, 4'b1011);
        chk("ares_reowner", owner, 2);

        // Master 2 finishes; no further requests
        req_n   = 4'hF;
        frame_n = 1'b0;
        step();
        step();
        chk("end_release", gnt_n, 4'hF);
        frame_n = 1'b1;
        step();
        step();
        chk("end_idle", gnt_n, 4'hF);
`ifdef PCI_ARB_PARK_EN
        for (int i = 0; i < 3; i++) begin
            step();
            chk("park_gnt", gnt_n, 4'b1011);
            chk("park_owner", owner, 2);
            chk("park_no_tmo", timeout_pulse, 0);
        end
        req_n = 4'b1110;
        step();
        chk("park_drop", gnt_n, 4'hF);
        step();
        chk("park_regrant", gnt_n, 4'b1110);
        chk("park_reowner", owner, 0);
`else
        for (int i = 0; i < 3; i++) begin
            step();
            chk("nopark_gnt", gnt_n, 4'hF);
            chk("nopark_owner", owner, 2);
        end
        req_n = 4'b1110;
        step();
        chk("nopark_grant", gnt_n, 4'b1110);
        chk("nopark_owner0", owner, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pci_rr_arbiter.md
Name: pci_rr_arbiter

Overview:
- Parametrised central arbiter for the shared PCI-style bus; the next generation of the fixed 3-master `arbiter` block.
- Round-robin fairness over N_MASTERS active-low request/grant pairs.
- Tracks bus activity from frame_n/irdy_n, so grants hand over only when the bus is idle.
- Revokes a grant the owner does not use within a timeout; optional bus parking.

Parameters:
- N_MASTERS, 4, number of request/grant channels (2..16)
- OWNER_W, 2, width of owner index; must be >= clog2(N_MASTERS)
- GNT_TIMEOUT, 16, cycles a granted master may leave FRAME# unasserted before the grant is revoked (>=2)
- TMR_W, 5, width of timeout counter; must hold GNT_TIMEOUT

Ports:
- clk  in  1  bus clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_n  in  N_MASTERS  request per master, active low
- frame_n  in  1  bus FRAME#, active low
- irdy_n  in  1  bus IRDY#, active low
- gnt_n  out  N_MASTERS  grant per master, active low, registered, at most one low
- owner  out  OWNER_W  index of master currently or last granted
- bus_busy  out  1  high when frame_n==0 or irdy_n==0, registered
- timeout_pulse  out  1  one-cycle high when a grant is revoked for timeout

Behaviour:
- Reset (async assert, sync release): gnt_n all 1, owner=0, bus_busy=0, timeout_pulse=0, rr pointer=N_MASTERS-1 (master 0 wins first), timer=0, state IDLE.
- Round-robin pick: the first asserted req_n scanning from rr_ptr+1 upward with wrap-around. The winner becomes owner; rr_ptr is set to the winner on grant.
- States:
  - IDLE:
    - No grant (unless parked, see Optional Feature).
    - If any req_n low and bus idle (frame_n=1 and irdy_n=1): drive winner's gnt_n low next cycle, go to GRANT.
    - Latency from req_n low to gnt_n low is 1 clock when the bus is idle.
  - GRANT:
    - Timer increments each cycle.
    - frame_n sampled 0: go to BUSY, clear timer.
    - Owner's req_n returns to 1 before frame_n: release gnt, go to TURN.
    - Timer reaches GNT_TIMEOUT-1: release gnt, pulse timeout_pulse, go to TURN. rr_ptr already points past this owner, so it loses priority.
  - BUSY:
    - Keep gnt while owner's req_n is low and no other req_n is low.
    - If another master requests or owner's req_n goes 1: release owner's gnt next cycle. The transaction in flight completes regardless.
    - Go to WAIT_IDLE when gnt is released.
  - WAIT_IDLE: all gnt_n high; stay until frame_n=1 and irdy_n=1 sampled, then go to TURN.
  - TURN: one mandatory cycle with all gnt_n high (bus turnaround), then IDLE.
- A grant never moves directly from one master to another; at least one cycle of all-high gnt_n always separates grants.
- Simultaneous requests: resolved purely by rr order. A newly arriving request never pre-empts an in-progress grant decision in the same cycle.
- req_n change while in TURN: ignored until IDLE.
- Owner index outside 0..N_MASTERS-1 is impossible. Unused owner bits are 0.
- reset_n low mid-transaction: all gnt_n go 1 immediately (asynchronously); state returns to IDLE.

Optional Feature:
- Macro: PCI_ARB_PARK_EN.
- Defined:
  - In IDLE with no req_n low, gnt_n of the current owner is held low (bus park, owner unchanged); after reset this is master 0.
  - A parked master may start frame_n directly; arbiter goes IDLE to BUSY.
  - A request from another master removes the park grant for one TURN cycle before granting the winner.
  - Parking does not run the timeout.
- Undefined: gnt_n all high whenever no request is pending; no park path.

Test Plan:
- Reset: reset_n=0 with req_n=4'b0000 -> gnt_n=4'b1111, owner=0, timeout_pulse=0; release, bus idle -> gnt_n=4'b1110 one clock later.
- Round-robin: all four req_n held low; each owner asserts frame_n for 2 cycles after grant -> grant order 0,1,2,3,0, every handover separated by >=1 all-high cycle.
- Pre-emption: master 1 in BUSY, master 2 lowers req_n -> gnt_n[1] goes high next cycle; gnt_n[2] goes low only after frame_n=1 and irdy_n=1 plus one TURN cycle.
- Timeout: grant master 3 with GNT_TIMEOUT=16, frame_n held 1 -> after 16 cycles gnt_n[3]=1, timeout_pulse high for exactly 1 cycle, next pending master granted.
- Async reset mid-BUSY: reset_n low while frame_n=0 -> gnt_n=4'b1111 in the same cycle, no clock required.
- PCI_ARB_PARK_EN: no requests after master 2's transaction -> gnt_n stays 4'b1011; master 0 requests -> one all-high cycle, then gnt_n=4'b1110.
